stopwatch_ctrl: RTL and testbench

// - Control unit for the stopwatch datapath: turns raw go/clear push-buttons into counter commands.
// - Sequences the BCD counter through IDLE/RUN/PAUSE and issues a 0.1 s count-enable tick while running.
// - Sits between board buttons and the counter/display path inside the stopwatch top level.
// - Owns all button synchronisation and debouncing.

---
 rtl/stopwatch_ctrl.sv | 158 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button sync/debounce, IDLE/RUN/PAUSE sequencing and 0.1 s tick prescaler.
// Optional lap/freeze feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 2_000_000,
  parameter int TICK_DIV  = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_go,
  input  logic btn_clr,
  input  logic btn_lap,
  output logic cnt_en,
  output logic cnt_clr,
  output logic running,
  output logic freeze
);

  // state | meaning
  // IDLE  | counter cleared, waiting for go
  // RUN   | prescaler counting, cnt_en ticks issued
  // PAUSE | prescaler held, waiting for go to resume
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int PW  = $clog2(TICK_DIV);

  logic [NB-1:0]  raw, s1, s2, acc, acc_d, press;
  logic [DBW-1:0] dbc [NB];

`ifdef STOPWATCH_LAP_EN
  assign raw = {btn_lap, btn_clr, btn_go};
`else
  assign raw = {btn_clr, btn_go};
  logic unused_lap;
  assign unused_lap = btn_lap;
`endif

  // Level is accepted only after DB_CYCLES+1 consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      acc   <= '0;
      acc_d <= '0;
      for (int i = 0; i < NB; i++) dbc[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      acc_d <= acc;
      for (int i = 0; i < NB; i++) begin
        if (s2[i] != acc[i]) begin
          if (dbc[i] == DBW'(DB_CYCLES)) begin
            acc[i] <= s2[i];
            dbc[i] <= '0;
          end else begin
            dbc[i] <= dbc[i] + 1'b1;
          end
        end else begin
          dbc[i] <= '0;
        end
      end
    end
  end

  assign press = acc & ~acc_d;

  logic go_p, clr_p;
  assign go_p  = press[0];
  assign clr_p = press[1];

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic          cnt_en_n, cnt_clr_n;
`ifdef STOPWATCH_LAP_EN
  logic          frz, frz_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      frz     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      cnt_en  <= cnt_en_n;
      cnt_clr <= cnt_clr_n;
`ifdef STOPWATCH_LAP_EN
      frz     <= frz_n;
`endif
    end
  end

  // clr has priority over go; the prescaler only advances on RUN cycles with no go press.
  always_comb begin
    state_n   = state;
    presc_n   = presc;
    cnt_en_n  = 1'b0;
    cnt_clr_n = 1'b0;
`ifdef STOPWATCH_LAP_EN
    frz_n     = frz;
`endif
    if (clr_p) begin
      state_n   = IDLE;
      presc_n   = '0;
      cnt_clr_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
      frz_n     = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (go_p) begin
            state_n = RUN;
            presc_n = '0;
          end
        end
        RUN: begin
          if (go_p) begin
            state_n = PAUSE;
          end else if (presc == PW'(TICK_DIV - 1)) begin
            presc_n  = '0;
            cnt_en_n = 1'b1;
          end else begin
            presc_n = presc + 1'b1;
          end
        end
        PAUSE: begin
          if (go_p) state_n = RUN;
        end
        default: state_n = IDLE;
      endcase
`ifdef STOPWATCH_LAP_EN
      if (press[2]) begin
        if (state == RUN)        frz_n = ~frz;
        else if (state == PAUSE) frz_n = 1'b0;
      end
`endif
    end
  end

  assign running = (state == RUN);
`ifdef STOPWATCH_LAP_EN
  assign freeze = frz;
`else
  assign freeze = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random button activity,
// every cycle compared against a behavioural model of debounce and stopwatch rules.
module tb_stopwatch_ctrl;
  localparam int DB = 4;
  localparam int TD = 5;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_go = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
  logic cnt_en, cnt_clr, running, freeze;

  stopwatch_ctrl #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .btn_go(btn_go), .btn_clr(btn_clr), .btn_lap(btn_lap),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .running(running), .freeze(freeze)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  // Model: a raw level stable for DB+1 samples and differing from the accepted level is
  // accepted; an accepted rise acts on the stopwatch 3 edges after its last qualifying sample.
  int run_start [3];
  bit run_val [3];
  bit macc [3];
  bit cmd [3][MAXE];
  typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_t;
  mstate_t ms = M_IDLE;
  int runcyc = 0;
  bit e_en = 0, e_clr = 0, e_frz = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0] raw;
    int e;
    e = edge_n;
    raw = {btn_lap, btn_clr, btn_go};
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        run_val[b] = 1'b0;
        macc[b] = 1'b0;
        run_start[b] = e;
        for (int d = 0; d < 4; d++) if (e + d < MAXE) cmd[b][e+d] = 1'b0;
      end
      ms = M_IDLE; runcyc = 0; e_en = 0; e_clr = 0; e_frz = 0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (raw[b] != run_val[b]) begin
          run_val[b] = raw[b];
          run_start[b] = e;
        end
        if (run_val[b] != macc[b] && e - run_start[b] == DB) begin
          macc[b] = run_val[b];
          if (macc[b] && e + 3 < MAXE) cmd[b][e+3] = 1'b1;
        end
      end
      e_en = 0;
      e_clr = 0;
      if (cmd[1][e]) begin
        ms = M_IDLE; runcyc = 0; e_clr = 1; e_frz = 0;
      end else begin
`ifdef STOPWATCH_LAP_EN
        if (cmd[2][e]) begin
          if (ms == M_RUN) e_frz = !e_frz;
          else if (ms == M_PAUSE) e_frz = 0;
        end
`endif
        case (ms)
          M_IDLE:  if (cmd[0][e]) begin ms = M_RUN; runcyc = 0; end
          M_RUN: begin
            if (cmd[0][e]) ms = M_PAUSE;
            else begin
              runcyc++;
              if (runcyc % TD == 0) e_en = 1;
            end
          end
          M_PAUSE: if (cmd[0][e]) ms = M_RUN;
          default: ms = M_IDLE;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    edge_n++;
    #1;
    check_val("running", int'(running), int'(ms == M_RUN));
    check_val("cnt_en", int'(cnt_en), int'(e_en));
    check_val("cnt_clr", int'(cnt_clr), int'(e_clr));
    check_val("freeze", int'(freeze), int'(e_frz));
    check_val("en_clr_excl", int'(cnt_en & cnt_clr), 0);
  endtask

  task automatic press_go();
    btn_go = 1'b1; repeat (8) tick(); btn_go = 1'b0; repeat (10) tick();
  endtask
  task automatic press_clr();
    btn_clr = 1'b1; repeat (8) tick(); btn_clr = 1'b0; repeat (10) tick();
  endtask
  task automatic press_lap();
    btn_lap = 1'b1; repeat (8) tick(); btn_lap = 1'b0; repeat (10) tick();
  endtask

  initial begin
    int rise, en1, en2, cnt, hold[3];
    logic [2:0] lv;

    // Reset with go held: exactly one go press after release.
    btn_go = 1'b1;
    repeat (2) begin
      tick();
      check_val("rst_outs", int'({cnt_en, cnt_clr, running, freeze}), 0);
    end
    rst = 1'b0;
    repeat (20) tick();
    check_val("reset_one_press", int'(running), 1);
    btn_go = 1'b0;
    repeat (10) tick();
    press_clr();

    // Start: running at edge 7, cnt_en at 12 and 17.
    btn_go = 1'b1; rise = -1; en1 = -1; en2 = -1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (running && rise < 0) rise = i;
      if (cnt_en && en1 < 0) en1 = i;
      else if (cnt_en && en2 < 0) en2 = i;
      if (i == 19) btn_go = 1'b0;
    end
    check_val("start_rise_edge", rise, 7);
    check_val("start_en1_edge", en1, 12);
    check_val("start_en2_edge", en2, 17);

    // Pause with prescaler at 2, then resume.
    for (int i = 0; i < 10 && (runcyc % TD) != 0; i++) tick();
    btn_go = 1'b1; cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (!running && cnt_en) cnt++;
      if (i == 9) btn_go = 1'b0;
    end
    check_val("pause_running", int'(running), 0);
    check_val("pause_no_en", cnt, 0);
    btn_go = 1'b1; rise = -1; en1 = -1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (running && rise < 0) rise = i;
      if (rise >= 0 && cnt_en && en1 < 0) en1 = i;
      if (i == 9) btn_go = 1'b0;
    end
    check_val("resume_first_en", en1 - rise, 3);
    repeat (6) tick();

    // Simultaneous go+clr in RUN: clr wins.
    btn_go = 1'b1; btn_clr = 1'b1; cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cnt_clr) cnt++;
      if (i == 9) begin btn_go = 1'b0; btn_clr = 1'b0; end
    end
    check_val("clr_pulse_count", cnt, 1);
    check_val("clr_running", int'(running), 0);
    repeat (5) tick();
    btn_go = 1'b1; rise = -1; en1 = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (running && rise < 0) rise = i;
      if (rise >= 0 && cnt_en && en1 < 0) en1 = i;
      if (i == 9) btn_go = 1'b0;
    end
    check_val("restart_first_en", en1 - rise, TD);
    press_clr();

    // Bounce: toggling every 2 cycles never qualifies.
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      btn_go = (i < 12) ? logic'(((i / 2) % 2) == 0) : 1'b0;
      tick();
      if (running || cnt_en) cnt++;
    end
    check_val("bounce_ignored", cnt, 0);

`ifdef STOPWATCH_LAP_EN
    press_go();
    press_lap();
    check_val("lap_freeze_on", int'(freeze), 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (cnt_en) cnt++; end
    check_val("lap_en_count", cnt, 4);
    press_lap();
    check_val("lap_freeze_off", int'(freeze), 0);
    press_lap();
    check_val("lap_freeze_again", int'(freeze), 1);
    btn_clr = 1'b1; cnt = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (cnt_clr) cnt++;
      if (i == 7) btn_clr = 1'b0;
    end
    check_val("lap_clr_pulse", cnt, 1);
    check_val("lap_clr_freeze", int'(freeze), 0);
`endif

    // Random activity with occasional resets.
    lv = 3'b000;
    btn_go = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
    hold[0] = 3; hold[1] = 40; hold[2] = 10;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b0;
      end
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          lv[b] = ~lv[b];
          case (b)
            0: hold[b] = lv[b] ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 25));
            1: hold[b] = lv[b] ? int'($urandom_range(1, 10)) : int'($urandom_range(5, 80));
            default: hold[b] = lv[b] ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 30));
          endcase
        end else begin
          hold[b]--;
        end
      end
      btn_go = lv[0]; btn_clr = lv[1]; btn_lap = lv[2];
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
